mem_bridge_arbiter: RTL
=======================

# mem_bridge_arbiter

Shares the CPU's single external memory bridge between instruction fetch and the data-memory stage. It grants one requester at a time, holds the bus transaction until acknowledged, and returns read data with a one-cycle ready pulse. It drops fetch responses that arrive after a branch-correction flush, and bounds fetch starvation under data-heavy code. It sits between the pipeline stages (IF/MEM) and the bridge port of the top-level `mips` core.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` bits wide.
- `MAX_STARVE`, 4, number of consecutive data grants allowed while fetch waits; must be ≥1.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_ready`.
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req` is high.
- `if_flush`  in  1  branch-correction flush pulse.
- `if_ready`  out  1  one-cycle fetch completion pulse.
- `if_rdata`  out  DATA_W  fetched word; valid when `if_ready`.
- `dm_req`  in  1  data request; held until `dm_ready`.
- `dm_we`  in  1  1 means write.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  write data.
- `dm_be`  in  DATA_W/8  byte enables.
- `dm_ready`  out  1  one-cycle data completion pulse.
- `dm_rdata`  out  DATA_W  load data; valid when `dm_ready`.
- `bus_req`  out  1  bridge request.
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`  out  1 / ADDR_W / DATA_W / DATA_W/8  bridge command.
- `bus_ack`  in  1  bridge completion; may arrive in the first cycle of `bus_req`.
- `bus_rdata`  in  DATA_W  read data; valid with `bus_ack`.
- `busy`  out  1  high in any state except IDLE.

## Operation
- States:
  - IDLE
  - GRANT_D (data transaction outstanding)
  - GRANT_I (fetch transaction outstanding)
  - RESP (one response cycle)
- Arbitration in IDLE:
  - Effective fetch request is `if_req & ~if_flush`.
  - If both requests are present, data wins unless `starve_cnt == MAX_STARVE`; in that case fetch wins.
  - Only one request present: that requester is granted.
  - Neither present: stay in IDLE.
- On grant:
  - Register the command into the `bus_*` outputs.
  - Set `bus_req = 1`. For a fetch grant, `bus_we = 0` and `bus_be = all-ones`.
  - Record the owner.
- Starvation counter `starve_cnt` (saturating at `MAX_STARVE`):
  - Increments on a data grant while the effective fetch request is high.
  - Clears on a fetch grant.
  - Otherwise unchanged.
- GRANT_x:
  - Hold `bus_req` and the command stable until `bus_ack`.
  - On `bus_ack`: register `bus_rdata` into the owner's `rdata`, drop `bus_req`, go to RESP.
- RESP:
  - Pulse the owner's ready for exactly one cycle. A write still pulses `dm_ready`; `dm_rdata` is don't-care for writes.
  - Then return to IDLE.
  - No arbitration takes place in RESP.
- Flush handling:
  - `if_flush` in GRANT_I sets the `drop` flag. The bus transaction still completes (bridge transactions cannot be aborted). The following RESP suppresses `if_ready` and leaves `if_rdata` unchanged.
  - `if_flush` during a fetch RESP masks `if_ready` combinationally.
  - `drop` clears on entry to IDLE.
  - `if_flush` has no effect on data transactions.
- Requester contract:
  - A requester's `req` is low in the cycle after its ready pulse unless it is issuing a new request.
  - Address and data are stable from `req` rise until ready.

## Timing
- Reset values (asynchronous): state IDLE, `starve_cnt = 0`, `drop = 0`, and every output 0, including `bus_req`, all `bus_*` fields, `if_ready`, `dm_ready`, both `rdata` outputs and `busy`.
- Reset asserted mid-transaction drops `bus_req` immediately. The bridge must discard the abandoned access.
- Minimum latency with request sampled in IDLE at cycle 0:
  - cycle 1: `bus_req` high.
  - cycle 1 (if ack arrives immediately): `bus_ack`.
  - cycle 2: ready pulse.
  - cycle 3: back in IDLE.
- Total: 2 cycles request-to-ready, 3 cycles between back-to-back grants.
- Each ack-wait cycle adds exactly one cycle of latency.
- Ready outputs are registered except for the `if_flush` masking in RESP.
- `bus_ack` is ignored outside GRANT_x.

## Test plan
- Single fetch: `if_req`, `if_addr=0x00400000`; bridge acks on the first cycle with `0x2408000A` → `bus_req` high in cycle 1, `if_ready` pulses in cycle 2 with `if_rdata=0x2408000A`, `busy` low in cycle 3.
- Simultaneous requests: `dm_req` (write `0x10010000`, `wdata=0xDEADBEEF`, `be=4'b1111`) and `if_req` in the same cycle → data granted first with `bus_we=1`; fetch granted after the `dm_ready` pulse plus one cycle.
- Starvation: `if_req` held while `dm_req` is reasserted after every `dm_ready`, with `MAX_STARVE=4` → exactly 4 data grants, then a fetch grant, then `starve_cnt` returns to 0.
- Flush mid-fetch: grant a fetch, bridge waits 3 cycles, `if_flush` pulses in wait cycle 1 → the transaction completes, no `if_ready` pulse, `if_rdata` unchanged, `busy` low after RESP.
- Ack latency: bridge waits 5 cycles on a data read returning `0x12345678` → `bus_*` fields stable for 6 cycles, `dm_ready` exactly one cycle after ack with `dm_rdata=0x12345678`.
- Reset mid-transaction: assert `rst` asynchronously (between clock edges) in GRANT_D → `bus_req` and all outputs go to 0 immediately; after release, a new fetch completes normally.

Source files
------------

// File: rtl/mem_bridge_arbiter_if.sv
// Bundle of the fetch, data-memory and bridge signals around mem_bridge_arbiter.
//   if_*  : instruction-fetch requester (req/addr/flush in, ready/rdata out)
//   dm_*  : data-memory requester (req/we/addr/wdata/be in, ready/rdata out)
//   bus_* : external memory bridge (command out, ack/rdata in)
//   busy  : arbiter is not idle
// modport master is the arbiter's view; modport slave is the surrounding pipeline/bridge.
interface mem_bridge_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_ready;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [BE_W-1:0]   dm_be;
   logic              dm_ready;
   logic [DATA_W-1:0] dm_rdata;

   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [BE_W-1:0]   bus_be;
   logic              bus_ack;
   logic [DATA_W-1:0] bus_rdata;

   logic              busy;

   modport master (
      input  if_req, if_addr, if_flush,
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      input  bus_ack, bus_rdata,
      output if_ready, if_rdata, dm_ready, dm_rdata,
      output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      output busy
   );

   modport slave (
      output if_req, if_addr, if_flush,
      output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      output bus_ack, bus_rdata,
      input  if_ready, if_rdata, dm_ready, dm_rdata,
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      input  busy
   );
endinterface

// File: rtl/mem_bridge_arbiter.sv
// Shares one external memory bridge between instruction fetch and the data stage.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bif  : mem_bridge_arbiter_if.master (fetch, data and bridge signals)
// Data wins contention unless fetch has been passed over MAX_STARVE times in a row.
// Fetch responses flushed while outstanding are completed on the bus but not delivered.
module mem_bridge_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MAX_STARVE = 4
) (
   input logic                  clk,
   input logic                  rst,
   mem_bridge_arbiter_if.master bif
);
   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = $clog2(MAX_STARVE + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_D = 2'd1,
      GRANT_I = 2'd2,
      RESP    = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              drop_q, drop_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic [BE_W-1:0]   bus_be_q, bus_be_d;
   logic              if_ready_q, if_ready_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              dm_ready_q, dm_ready_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              busy_q, busy_d;

   // Arbitration decode, only acted on in IDLE.
   logic if_eff, starved, pick_i, pick_d;
   assign if_eff  = bif.if_req & ~bif.if_flush;
   assign starved = (starve_cnt_q == CNT_W'(MAX_STARVE));
   assign pick_i  = if_eff & (~bif.dm_req | starved);
   assign pick_d  = bif.dm_req & ~pick_i;

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         drop_q       <= 1'b0;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         bus_be_q     <= '0;
         if_ready_q   <= 1'b0;
         if_rdata_q   <= '0;
         dm_ready_q   <= 1'b0;
         dm_rdata_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         drop_q       <= drop_d;
         bus_req_q    <= bus_req_d;
         bus_we_q     <= bus_we_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         bus_be_q     <= bus_be_d;
         if_ready_q   <= if_ready_d;
         if_rdata_q   <= if_rdata_d;
         dm_ready_q   <= dm_ready_d;
         dm_rdata_q   <= dm_rdata_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pick_d)      state_d = GRANT_D;
            else if (pick_i) state_d = GRANT_I;
         end
         GRANT_D, GRANT_I: if (bif.bus_ack) state_d = RESP;
         RESP:             state_d = IDLE;
      endcase
   end

   // Command capture, response capture and bookkeeping.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      drop_d       = drop_q;
      bus_req_d    = bus_req_q;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      bus_be_d     = bus_be_q;
      if_ready_d   = 1'b0;
      if_rdata_d   = if_rdata_q;
      dm_ready_d   = 1'b0;
      dm_rdata_d   = dm_rdata_q;
      busy_d       = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (pick_d) begin
               bus_req_d   = 1'b1;
               bus_we_d    = bif.dm_we;
               bus_addr_d  = bif.dm_addr;
               bus_wdata_d = bif.dm_wdata;
               bus_be_d    = bif.dm_be;
               if (if_eff && !starved) starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end else if (pick_i) begin
               bus_req_d    = 1'b1;
               bus_we_d     = 1'b0;
               bus_addr_d   = bif.if_addr;
               bus_wdata_d  = '0;
               bus_be_d     = '1;
               starve_cnt_d = '0;
            end
         end
         GRANT_D: begin
            if (bif.bus_ack) begin
               bus_req_d  = 1'b0;
               dm_rdata_d = bif.bus_rdata;
               dm_ready_d = 1'b1;
            end
         end
         GRANT_I: begin
            if (bif.if_flush) drop_d = 1'b1;
            if (bif.bus_ack) begin
               bus_req_d = 1'b0;
               // A flush in the ack cycle itself also discards the word.
               if (!(drop_q || bif.if_flush)) begin
                  if_rdata_d = bif.bus_rdata;
                  if_ready_d = 1'b1;
               end
            end
         end
         RESP: drop_d = 1'b0;
      endcase
   end

   assign bif.bus_req   = bus_req_q;
   assign bif.bus_we    = bus_we_q;
   assign bif.bus_addr  = bus_addr_q;
   assign bif.bus_wdata = bus_wdata_q;
   assign bif.bus_be    = bus_be_q;
   // Late flush during the response cycle still cancels the fetch pulse.
   assign bif.if_ready  = if_ready_q & ~bif.if_flush;
   assign bif.if_rdata  = if_rdata_q;
   assign bif.dm_ready  = dm_ready_q;
   assign bif.dm_rdata  = dm_rdata_q;
   assign bif.busy      = busy_q;
endmodule
